// File: rtl/rf_pkg.sv
// Shared defaults and clear-engine state encoding for the integer register file.
package rf_pkg;

    localparam int unsigned RF_XLEN  = 32;
    localparam int unsigned RF_NREGS = 32;
    localparam int unsigned RF_NRD   = 2;

    typedef enum logic [0:0] {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_clear_ctrl.sv
// Sequential clear engine: walks every register index once per request and
// reports progress through clr_busy / clr_done.
module rf_clear_ctrl
    import rf_pkg::*;
#(
    parameter  int unsigned NREGS = RF_NREGS,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state_r;
    logic [AW-1:0] cnt_r;

    assign clr_en   = (state_r == RF_CLEAR);
    assign clr_addr = cnt_r;

    // Clear FSM; the counter parks on the last index so a pass never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= RF_IDLE;
            cnt_r    <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state_r)
                RF_IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state_r  <= RF_CLEAR;
                        cnt_r    <= '0;
                        clr_busy <= 1'b1;
                    end else begin
                        clr_busy <= 1'b0;
                    end
                end
                RF_CLEAR: begin
                    if (cnt_r == AW'(NREGS - 1)) begin
                        state_r  <= RF_IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + AW'(1);
                    end
                end
                default: begin
                    state_r  <= RF_IDLE;
                    cnt_r    <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with one write port, optional write-to-read
// bypass, per-register pending bits and a sequential clear engine.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter  int unsigned XLEN     = RF_XLEN,
    parameter  int unsigned NREGS    = RF_NREGS,
    parameter  int unsigned NRD      = RF_NRD,
    parameter  bit          ZERO_REG = 1'b1,
    parameter  bit          BYPASS   = 1'b1,
    localparam int unsigned AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWEn,
    input  logic [AW-1:0]     w_reg,
    input  logic [XLEN-1:0]   w_data,
    input  logic [NRD*AW-1:0] r_reg,
    output logic [NRD*XLEN-1:0] r_data,
    output logic [NRD-1:0]    r_pend,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_reg,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    logic [XLEN-1:0] regs_r [NREGS];
    logic [NREGS-1:0] pend_r;

    logic          wr_acc_s;
    logic          sb_ok_s;
    logic          clr_en_s;
    logic [AW-1:0] clr_addr_s;

    rf_clear_ctrl #(.NREGS(NREGS)) u_clr (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .clr_en   (clr_en_s),
        .clr_addr (clr_addr_s)
    );

    // Writes are dropped while the clear engine owns the array.
    assign wr_acc_s = RegWEn && !clr_busy && !(ZERO_REG && (w_reg == '0));
    assign sb_ok_s  = sb_set && !(ZERO_REG && (sb_reg == '0));

    // Register storage: clear strobe has priority over a (never coincident) write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (clr_en_s && (clr_addr_s == AW'(i))) begin
                    regs_r[i] <= '0;
                end else if (wr_acc_s && (w_reg == AW'(i))) begin
                    regs_r[i] <= w_data;
                end
            end
        end
    end

    // Scoreboard: a new producer outranks the write retiring the old one,
    // and the clear sweep outranks both.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_r <= '0;
        end else begin
            for (int i = 0; i < int'(NREGS); i++) begin
                if (clr_en_s && (clr_addr_s == AW'(i))) begin
                    pend_r[i] <= 1'b0;
                end else if (sb_ok_s && (sb_reg == AW'(i))) begin
                    pend_r[i] <= 1'b1;
                end else if (wr_acc_s && (w_reg == AW'(i))) begin
                    pend_r[i] <= 1'b0;
                end
            end
        end
    end

    for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
        logic [AW-1:0]   addr_s;
        logic            hit_s;
        logic [XLEN-1:0] data_s;
        logic            pend_s;

        assign addr_s = r_reg[k*AW +: AW];
        assign hit_s  = BYPASS && wr_acc_s && (w_reg == addr_s);

        // Read mux: zero register, then forwarded write, then stored state.
        always_comb begin
            data_s = regs_r[addr_s];
            pend_s = pend_r[addr_s];
            if (ZERO_REG && (addr_s == '0)) begin
                data_s = '0;
                pend_s = 1'b0;
            end else if (hit_s) begin
                data_s = w_data;
                pend_s = (sb_ok_s && (sb_reg == addr_s)) ? pend_r[addr_s] : 1'b0;
            end else begin
                data_s = regs_r[addr_s];
                pend_s = pend_r[addr_s];
            end
        end

        assign r_data[k*XLEN +: XLEN] = data_s;
        assign r_pend[k]              = pend_s;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed plus randomized bench for reg_file_mp against an array-based model.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_wen, a_sbset, a_clrreq, a_busy, a_done;
    logic [4:0]  a_wreg, a_sbreg;
    logic [31:0] a_wdata;
    logic [9:0]  a_rreg;
    logic [63:0] a_rdata;
    logic [1:0]  a_rpend;

    logic        b_wen, b_sbset, b_clrreq, b_busy, b_done;
    logic [3:0]  b_wreg, b_sbreg;
    logic [31:0] b_wdata;
    logic [11:0] b_rreg;
    logic [95:0] b_rdata;
    logic [2:0]  b_rpend;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] am_regs [32];
    bit          am_pend [32];
    int          am_idx;
    bit          am_done;
    logic [31:0] bm_regs [16];
    bit          bm_pend [16];

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .RegWEn(a_wen), .w_reg(a_wreg), .w_data(a_wdata),
        .r_reg(a_rreg), .r_data(a_rdata), .r_pend(a_rpend), .sb_set(a_sbset),
        .sb_reg(a_sbreg), .clr_req(a_clrreq), .clr_busy(a_busy), .clr_done(a_done)
    );

    reg_file_mp #(.XLEN(32), .NREGS(16), .NRD(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .RegWEn(b_wen), .w_reg(b_wreg), .w_data(b_wdata),
        .r_reg(b_rreg), .r_data(b_rdata), .r_pend(b_rpend), .sb_set(b_sbset),
        .sb_reg(b_sbreg), .clr_req(b_clrreq), .clr_busy(b_busy), .clr_done(b_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic models_reset();
        for (int i = 0; i < 32; i++) begin
            am_regs[i] = 32'd0;
            am_pend[i] = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            bm_regs[i] = 32'd0;
            bm_pend[i] = 1'b0;
        end
        am_idx  = -1;
        am_done = 1'b0;
    endtask

    // Check instance A before the edge, then advance the model and the clock.
    task automatic cycle_a();
        int          addr;
        logic [31:0] ed;
        bit          ep, acc, sbok, nd;
        #1;
        acc  = a_wen && (am_idx < 0) && (a_wreg != 5'd0);
        sbok = a_sbset && (a_sbreg != 5'd0);
        for (int k = 0; k < 2; k++) begin
            addr = int'(a_rreg[k*5 +: 5]);
            if (addr == 0) begin
                ed = 32'd0;
                ep = 1'b0;
            end else if (acc && (int'(a_wreg) == addr)) begin
                ed = a_wdata;
                ep = (sbok && (int'(a_sbreg) == addr)) ? am_pend[addr] : 1'b0;
            end else begin
                ed = am_regs[addr];
                ep = am_pend[addr];
            end
            chk($sformatf("a_rdata%0d_r%0d", k, addr), a_rdata[k*32 +: 32], ed);
            chk($sformatf("a_rpend%0d_r%0d", k, addr), {31'd0, a_rpend[k]}, {31'd0, ep});
        end
        chk("a_clr_busy", {31'd0, a_busy}, {31'd0, (am_idx >= 0)});
        chk("a_clr_done", {31'd0, a_done}, {31'd0, am_done});
        if (acc) begin
            am_regs[a_wreg] = a_wdata;
            am_pend[a_wreg] = 1'b0;
        end
        if (sbok) am_pend[a_sbreg] = 1'b1;
        nd = 1'b0;
        if (am_idx < 0) begin
            if (a_clrreq) am_idx = 0;
        end else begin
            am_regs[am_idx] = 32'd0;
            am_pend[am_idx] = 1'b0;
            am_idx++;
            if (am_idx == 32) begin
                am_idx = -1;
                nd     = 1'b1;
            end
        end
        am_done = nd;
        @(posedge clk);
        #1;
    endtask

    // Instance B has no bypass: a same-cycle read always sees stored state.
    task automatic cycle_b();
        int          addr;
        logic [31:0] ed;
        bit          ep;
        #1;
        for (int k = 0; k < 3; k++) begin
            addr = int'(b_rreg[k*4 +: 4]);
            ed   = (addr == 0) ? 32'd0 : bm_regs[addr];
            ep   = (addr == 0) ? 1'b0 : bm_pend[addr];
            chk($sformatf("b_rdata%0d_r%0d", k, addr), b_rdata[k*32 +: 32], ed);
            chk($sformatf("b_rpend%0d_r%0d", k, addr), {31'd0, b_rpend[k]}, {31'd0, ep});
        end
        chk("b_clr_busy", {31'd0, b_busy}, 32'd0);
        if (b_wen && (b_wreg != 4'd0)) begin
            bm_regs[b_wreg] = b_wdata;
            bm_pend[b_wreg] = 1'b0;
        end
        if (b_sbset && (b_sbreg != 4'd0)) bm_pend[b_sbreg] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_wen    = 1'b0;
        a_sbset  = 1'b0;
        a_clrreq = 1'b0;
    endtask

    initial begin
        int busy_cnt, done_cnt;
        rst = 1'b0;
        a_idle();
        a_wreg = 5'd0; a_sbreg = 5'd0; a_wdata = 32'd0; a_rreg = 10'd0;
        b_wen = 1'b0; b_sbset = 1'b0; b_clrreq = 1'b0;
        b_wreg = 4'd0; b_sbreg = 4'd0; b_wdata = 32'd0; b_rreg = 12'd0;
        models_reset();
        #2;
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        a_rreg = {5'd5, 5'd0};
        cycle_a();

        a_wen = 1'b1; a_wreg = 5'd5; a_wdata = 32'hDEADBEEF; a_rreg = {5'd5, 5'd5};
        cycle_a();
        a_wen = 1'b0;
        cycle_a();
        chk("wr5_stored", a_rdata[63:32], 32'hDEADBEEF);

        a_wen = 1'b1; a_wreg = 5'd0; a_wdata = 32'h12345678; a_rreg = {5'd0, 5'd0};
        cycle_a();
        a_wen = 1'b0;
        cycle_a();
        chk("wr0_reads0", a_rdata[31:0], 32'd0);

        a_sbset = 1'b1; a_sbreg = 5'd7; a_rreg = {5'd7, 5'd7};
        cycle_a();
        a_sbset = 1'b0;
        chk("sb7_pend", {30'd0, a_rpend}, 32'd3);
        cycle_a();
        a_wen = 1'b1; a_wreg = 5'd7; a_wdata = 32'd77;
        cycle_a();
        a_wen = 1'b0;
        chk("wr7_unpend", {30'd0, a_rpend}, 32'd0);
        cycle_a();
        a_wen = 1'b1; a_sbset = 1'b1; a_wdata = 32'h0707;
        cycle_a();
        a_idle();
        chk("sbwr7_pend", {30'd0, a_rpend}, 32'd3);
        chk("sbwr7_data", a_rdata[31:0], 32'h0707);

        repeat (300) begin
            a_wen   = 1'($urandom_range(0, 1));
            a_wreg  = 5'($urandom);
            a_wdata = $urandom;
            a_rreg  = 10'($urandom);
            a_sbset = ($urandom_range(0, 3) == 0);
            a_sbreg = 5'($urandom);
            cycle_a();
        end
        a_idle();

        for (int i = 1; i < 32; i++) begin
            a_wen = 1'b1; a_wreg = 5'(i); a_wdata = 32'(i); a_rreg = {5'(i), 5'(i - 1)};
            cycle_a();
        end
        a_idle();

        a_clrreq = 1'b1;
        cycle_a();
        a_clrreq = 1'b0;
        busy_cnt = int'(a_busy);
        done_cnt = int'(a_done);
        for (int c = 0; c < 40; c++) begin
            a_rreg   = 10'($urandom);
            a_wen    = (c == 5);
            a_wreg   = 5'd3;
            a_wdata  = 32'hFFFF0003;
            a_clrreq = (c == 8);
            a_sbset  = (c == 12) || (c == 14);
            a_sbreg  = (c == 12) ? 5'd2 : 5'd30;
            cycle_a();
            busy_cnt += int'(a_busy);
            done_cnt += int'(a_done);
        end
        a_idle();
        chk("clr_busy_cycles", busy_cnt, 32'd32);
        chk("clr_done_pulses", done_cnt, 32'd1);
        for (int i = 0; i < 16; i++) begin
            a_rreg = {5'(2 * i + 1), 5'(2 * i)};
            cycle_a();
        end
        a_rreg = {5'd30, 5'd3};
        #1;
        chk("clr_wr3_lost", a_rdata[31:0], 32'd0);
        chk("clr_sb_kept_lost", {30'd0, a_rpend}, 32'd0);
        a_rreg = {5'd30, 5'd2};
        #1;
        chk("clr_sb2_kept", {31'd0, a_rpend[0]}, 32'd1);

        repeat (10) begin
            a_wen = 1'b1; a_wreg = 5'($urandom); a_wdata = $urandom;
            cycle_a();
        end
        a_idle();
        a_clrreq = 1'b1;
        cycle_a();
        a_clrreq = 1'b0;
        repeat (10) cycle_a();
        rst = 1'b0;
        #1;
        chk("midclr_busy", {31'd0, a_busy}, 32'd0);
        chk("midclr_done", {31'd0, a_done}, 32'd0);
        models_reset();
        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a_rreg = {5'(2 * i + 1), 5'(2 * i)};
            cycle_a();
        end

        b_wen = 1'b1; b_wreg = 4'd9; b_wdata = 32'h0000AAAA; b_rreg = {4'd9, 4'd9, 4'd9};
        cycle_b();
        b_wdata = 32'h00001234;
        #1;
        chk("b_nobypass", b_rdata[31:0], 32'h0000AAAA);
        cycle_b();
        for (int i = 1; i < 16; i++) begin
            b_wreg = 4'(i); b_wdata = 32'h1111 * 32'(i);
            cycle_b();
        end
        b_wen = 1'b0;
        b_rreg = {4'd12, 4'd7, 4'd3};
        #1;
        chk("b_port0_r3", b_rdata[31:0], 32'h3333);
        chk("b_port1_r7", b_rdata[63:32], 32'h7777);
        chk("b_port2_r12", b_rdata[95:64], 32'hCCCC);
        repeat (150) begin
            b_wen   = 1'($urandom_range(0, 1));
            b_wreg  = 4'($urandom);
            b_wdata = $urandom;
            b_rreg  = 12'($urandom);
            b_sbset = ($urandom_range(0, 3) == 0);
            b_sbreg = 4'($urandom);
            cycle_b();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
